// File: rtl/alpha_seq_ctrl.sv
// alpha_seq_ctrl: issues seed*alpha^k over GF(2^32) (x^32+x^8+1), one per valid/ready handshake.
// Optional feature: define ALPHA_SEQ_INV_EN to add dir_i and the alpha^-1 step.
module alpha_seq_ctrl #(
   parameter int NSTEPS = 12,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [31:0]      seed_i,
`ifdef ALPHA_SEQ_INV_EN
   input  logic             dir_i,
`endif
   output logic [31:0]      rc_o,
   output logic             rc_valid_o,
   input  logic             rc_ready_i,
   output logic [CNT_W-1:0] idx_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEPS - 1);
   logic [1:0]       fsm, fsm_nxt;
   logic [31:0]      cur, cur_nxt;
   logic [CNT_W-1:0] cnt;
   logic             hs, last, accept;
   function automatic logic [31:0] step_fwd(input logic [31:0] x);
      return {x[30:0], x[31]} ^ {23'b0, x[31], 8'b0};
   endfunction
`ifdef ALPHA_SEQ_INV_EN
   logic dir;
   function automatic logic [31:0] step_inv(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ {31'b0, x[0]} ^ {23'b0, x[0], 8'b0};
      return {x[0], t[31:1]};
   endfunction
   assign cur_nxt = dir ? step_inv(cur) : step_fwd(cur);
`else
   assign cur_nxt = step_fwd(cur);
`endif
   assign hs     = (fsm == RUN) && rc_ready_i;
   assign last   = cnt == LAST;
   assign accept = (fsm == IDLE) && start_i;
   // state register
   always_ff @(posedge clk)
      if (!rst_n) fsm <= IDLE;
      else        fsm <= fsm_nxt;
   // next-state: one run per accepted start, one DONE cycle, back to IDLE
   always_comb
      fsm_nxt = (fsm == IDLE) ? (start_i ? RUN : IDLE) :
                (fsm == RUN)  ? ((hs && last) ? DONE : RUN) : IDLE;
   // constant and index datapath; value held bit-stable between handshakes and after the run
   always_ff @(posedge clk)
      if (!rst_n) begin
         cur <= '0;
         cnt <= '0;
`ifdef ALPHA_SEQ_INV_EN
         dir <= 1'b0;
`endif
      end else if (accept) begin
         cur <= seed_i;
         cnt <= '0;
`ifdef ALPHA_SEQ_INV_EN
         dir <= dir_i;
`endif
      end else if (hs && !last) begin
         cur <= cur_nxt;
         cnt <= cnt + CNT_W'(1);
      end
   // outputs decoded from the FSM state
   always_comb begin
      rc_valid_o = fsm == RUN;
      busy_o     = fsm != IDLE;
      done_o     = fsm == DONE;
      rc_o       = cur;
      idx_o      = cnt;
   end
endmodule

// File: tb/tb_alpha_seq_ctrl.sv
// tb_alpha_seq_ctrl: directed self-checking bench for alpha_seq_ctrl (NSTEPS=12, CNT_W=4).
module tb_alpha_seq_ctrl;
   logic        clk = 0, rst_n = 0, start = 0, ready = 0;
   logic [31:0] seed = '0, rc;
   logic        valid, busy, done;
   logic [3:0]  idx;
   int          n_cmp = 0, n_err = 0;
`ifdef ALPHA_SEQ_INV_EN
   logic        dir = 0;
   logic [31:0] fwd_end;
`endif
   always #5 clk = ~clk;
   alpha_seq_ctrl #(.NSTEPS(12), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .seed_i(seed),
`ifdef ALPHA_SEQ_INV_EN
      .dir_i(dir),
`endif
      .rc_o(rc), .rc_valid_o(valid), .rc_ready_i(ready),
      .idx_o(idx), .busy_o(busy), .done_o(done)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic begin_run(input logic [31:0] s);
      seed  = s;
      start = 1;
      tick();
      start = 0;
   endtask
   task automatic run_to_idle();
      int n = 0;
      ready = 1;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask
   initial begin
      int hs, dn;
      tick();
      tick();
      check("rst_rc", rc, 32'd0);
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_idx", {28'b0, idx}, 32'd0);
      rst_n = 1;
      ready = 1;
      begin_run(32'h1);
      for (int k = 0; k < 12; k++) begin
         check($sformatf("t1_rc%0d", k), rc, 32'h1 << k);
         check($sformatf("t1_idx%0d", k), {28'b0, idx}, k);
         check($sformatf("t1_val%0d", k), {31'b0, valid}, 32'd1);
         check($sformatf("t1_done%0d", k), {31'b0, done}, 32'd0);
         tick();
      end
      check("t1_done", {31'b0, done}, 32'd1);
      check("t1_busy_done", {31'b0, busy}, 32'd1);
      check("t1_val_done", {31'b0, valid}, 32'd0);
      tick();
      check("t1_done_low", {31'b0, done}, 32'd0);
      check("t1_busy_low", {31'b0, busy}, 32'd0);
      begin_run(32'h8000_0000);
      check("t2_rc0", rc, 32'h8000_0000);
      tick();
      check("t2_rc1", rc, 32'h0000_0101);
      tick();
      check("t2_rc2", rc, 32'h0000_0202);
      run_to_idle();
      begin_run(32'h1);
      tick();
      tick();
      check("t3_idx_pre", {28'b0, idx}, 32'd2);
      ready = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t3_hold_rc", rc, 32'h4);
         check("t3_hold_idx", {28'b0, idx}, 32'd2);
         check("t3_hold_val", {31'b0, valid}, 32'd1);
      end
      ready = 1;
      for (int k = 2; k < 12; k++) begin
         check($sformatf("t3_rc%0d", k), rc, 32'h1 << k);
         check($sformatf("t3_idx%0d", k), {28'b0, idx}, k);
         tick();
      end
      check("t3_done", {31'b0, done}, 32'd1);
      tick();
      begin_run(32'h1);
      for (int k = 0; k < 5; k++) tick();
      check("t4_idx5", {28'b0, idx}, 32'd5);
      rst_n = 0;
      start = 1;
      tick();
      start = 0;
      check("t4_val", {31'b0, valid}, 32'd0);
      check("t4_busy", {31'b0, busy}, 32'd0);
      check("t4_rc", rc, 32'd0);
      check("t4_idx", {28'b0, idx}, 32'd0);
      rst_n = 1;
      tick();
      check("t4_nodone", {31'b0, done}, 32'd0);
      check("t4_still_idle", {31'b0, busy}, 32'd0);
      begin_run(32'h8000_0000);
      check("t4_re_idx", {28'b0, idx}, 32'd0);
      check("t4_re_rc", rc, 32'h8000_0000);
      run_to_idle();
      begin_run(32'h1);
      hs = 0;
      dn = 0;
      for (int c = 0; c < 40 && dn == 0; c++) begin
         start = (c % 3) == 1;
         if (valid && ready) hs++;
         if (done) dn++;
         else tick();
      end
      check("t5_hs", hs, 32'd12);
      check("t5_done", dn, 32'd1);
      start = 1;
      seed  = 32'h0000_0010;
      tick();
      check("t5_idle_after_done", {31'b0, busy}, 32'd0);
      check("t5_no_extra_done", {31'b0, done}, 32'd0);
      tick();
      start = 0;
      check("t5_b2b_valid", {31'b0, valid}, 32'd1);
      check("t5_b2b_rc", rc, 32'h0000_0010);
      check("t5_b2b_idx", {28'b0, idx}, 32'd0);
      run_to_idle();
`ifdef ALPHA_SEQ_INV_EN
      dir = 1;
      begin_run(32'h0000_0101);
      check("t6_rc0", rc, 32'h0000_0101);
      tick();
      check("t6_rc1", rc, 32'h8000_0000);
      tick();
      check("t6_rc2", rc, 32'h4000_0000);
      run_to_idle();
      dir = 0;
      begin_run(32'h1234_5678);
      ready = 0;
      while (idx != 4'd11 && busy) begin
         ready = 1;
         tick();
         ready = 0;
      end
      fwd_end = rc;
      run_to_idle();
      dir = 1;
      begin_run(fwd_end);
      ready = 0;
      while (idx != 4'd11 && busy) begin
         ready = 1;
         tick();
         ready = 0;
      end
      check("t6_roundtrip", rc, 32'h1234_5678);
      run_to_idle();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
